// File: rtl/instr_mem_writer.sv
// Encodes decoded RV32I fields (lw, sw, sub, xor, addi, srl, beq) into machine words and
// writes them sequentially into instruction memory starting at word address 0.
module instr_mem_writer #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [12:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam int unsigned Depth = 1 << ADDR_W;

    localparam logic [2:0] OpLw   = 3'd0;
    localparam logic [2:0] OpSw   = 3'd1;
    localparam logic [2:0] OpSub  = 3'd2;
    localparam logic [2:0] OpXor  = 3'd3;
    localparam logic [2:0] OpAddi = 3'd4;
    localparam logic [2:0] OpSrl  = 3'd5;
    localparam logic [2:0] OpBeq  = 3'd6;

    typedef enum logic [1:0] {StIdle, StEnc, StWr, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [12:0] imm_q, imm_d;
    logic        last_q, last_d;
    logic [31:0] wdata_q, wdata_d;
    logic [ADDR_W:0] count_q, count_d;
    logic        err_q, err_d;
    logic [31:0] enc_word;

    // Unused register fields are dropped from the word, which forces them to zero.
    always_comb begin
        enc_word = '0;
        case (op_q)
            OpLw:   enc_word = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            OpAddi: enc_word = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
            OpSw:   enc_word = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            OpSub:  enc_word = {7'b0100000, rs2_q, rs1_q, 3'b000, rd_q, 7'b0110011};
            OpXor:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b100, rd_q, 7'b0110011};
            OpSrl:  enc_word = {7'b0000000, rs2_q, rs1_q, 3'b101, rd_q, 7'b0110011};
            OpBeq:  enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000,
                                imm_q[4:1], imm_q[11], 7'b1100011};
            default: enc_word = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        last_d  = last_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d    = op_sel;
                    rd_d    = rd;
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                    imm_d   = imm;
                    last_d  = last;
                    state_d = StEnc;
                end
            end
            StEnc: begin
                if (op_q == 3'd7) begin
                    err_d   = 1'b1;
                    state_d = last_q ? StDone : StIdle;
                end else begin
                    wdata_d = enc_word;
                    state_d = StWr;
                end
            end
            StWr: begin
                count_d = count_q + (ADDR_W+1)'(1);
                // A final word that exactly fills memory is not an overflow.
                if (last_q) begin
                    state_d = StDone;
                end else if (count_d == (ADDR_W+1)'(Depth)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StIdle;
                end
            end
            StDone: state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            last_q  <= 1'b0;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            last_q  <= last_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Strobe decoded straight from state so an async reset drops it immediately.
    assign in_ready  = (state_q == StIdle);
    assign mem_we    = (state_q == StWr);
    assign done      = (state_q == StDone);
    assign mem_addr  = count_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_mem_writer.sv
// Directed bench for instr_mem_writer: a 32-word instance for encoding/handshake cases and a
// 4-word instance for the overflow case.
module tb_instr_mem_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        sel_b = 1'b0;
    logic [2:0]  op_sel = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [12:0] imm = '0;
    logic        last = 1'b0;

    logic        a_in_ready, a_mem_we, a_done, a_err;
    logic [4:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [5:0]  a_count;
    logic        b_in_ready, b_mem_we, b_done, b_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_count;

    logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_mem_writer #(.ADDR_W(5)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel_b), .in_ready(a_in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .count(a_count),
        .done(a_done), .err(a_err)
    );

    instr_mem_writer #(.ADDR_W(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel_b), .in_ready(b_in_ready),
        .op_sel(op_sel), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .count(b_count),
        .done(b_done), .err(b_err)
    );

    always @(negedge clk) begin
        if (a_mem_we) begin
            qa_addr.push_back(32'(a_mem_addr));
            qa_data.push_back(a_mem_wdata);
        end
        if (b_mem_we) begin
            qb_addr.push_back(32'(b_mem_addr));
            qb_data.push_back(b_mem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
    endtask

    // Returns 1 ns after the handshake edge.
    task automatic send(input logic [2:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                        input logic [4:0] f_rs2, input logic [12:0] f_imm, input logic f_last);
        bit ok = 0;
        @(negedge clk);
        in_valid = 1'b1; op_sel = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
        imm = f_imm; last = f_last;
        for (int k = 0; k < 20; k++) begin
            if (sel_b ? b_in_ready : a_in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) check_val("handshake_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_val("rst_in_ready", 32'(a_in_ready), 32'd1);
        check_val("rst_mem_we", 32'(a_mem_we), 32'd0);
        check_val("rst_addr", 32'(a_mem_addr), 32'd0);
        check_val("rst_wdata", a_mem_wdata, 32'd0);
        check_val("rst_count", 32'(a_count), 32'd0);
        check_val("rst_done_err", 32'({a_done, a_err}), 32'd0);

        // addi x1,x0,5 with cycle-exact timing
        send(3'd4, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        @(negedge clk);
        check_val("addi_enc_no_we", 32'(a_mem_we), 32'd0);
        check_val("addi_enc_no_ready", 32'(a_in_ready), 32'd0);
        @(negedge clk);
        check_val("addi_we", 32'(a_mem_we), 32'd1);
        check_val("addi_addr", 32'(a_mem_addr), 32'd0);
        check_val("addi_wdata", a_mem_wdata, 32'h00500093);
        @(negedge clk);
        check_val("addi_we_low", 32'(a_mem_we), 32'd0);
        check_val("addi_count", 32'(a_count), 32'd1);
        check_val("addi_ready_back", 32'(a_in_ready), 32'd1);

        // sub x3,x1,x2 then sw x2,8(x1)
        do_reset();
        send(3'd2, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        send(3'd1, 5'd0, 5'd1, 5'd2, 13'd8, 1'b0);
        repeat (5) @(negedge clk);
        check_val("b2b_nwrites", 32'(qa_data.size()), 32'd2);
        check_val("sub_addr", qa_addr[0], 32'd0);
        check_val("sub_wdata", qa_data[0], 32'h402081B3);
        check_val("sw_addr", qa_addr[1], 32'd1);
        check_val("sw_wdata", qa_data[1], 32'h0020A423);
        check_val("b2b_count", 32'(a_count), 32'd2);

        // beq x1,x2,-4 with last
        do_reset();
        send(3'd6, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1);
        repeat (4) @(negedge clk);
        check_val("beq_wdata", qa_data[0], 32'hFE208EE3);
        check_val("beq_done", 32'(a_done), 32'd1);
        check_val("beq_ready", 32'(a_in_ready), 32'd0);
        check_val("beq_err", 32'(a_err), 32'd0);
        in_valid = 1'b1; op_sel = 3'd4; rd = 5'd1; imm = 13'd5; last = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check_val("done_no_more_writes", 32'(qa_data.size()), 32'd1);
        check_val("done_count", 32'(a_count), 32'd1);

        // lw x5,12(x0) then illegal op
        do_reset();
        send(3'd0, 5'd5, 5'd0, 5'd0, 13'd12, 1'b0);
        send(3'd7, 5'd1, 5'd1, 5'd1, 13'd1, 1'b0);
        repeat (4) @(negedge clk);
        check_val("ill_nwrites", 32'(qa_data.size()), 32'd1);
        check_val("lw_wdata", qa_data[0], 32'h00C02283);
        check_val("ill_err", 32'(a_err), 32'd1);
        check_val("ill_count", 32'(a_count), 32'd1);
        check_val("ill_ready", 32'(a_in_ready), 32'd1);
        check_val("ill_not_done", 32'(a_done), 32'd0);

        // async reset during the WR cycle
        do_reset();
        send(3'd3, 5'd4, 5'd1, 5'd2, 13'd0, 1'b0);
        @(posedge clk);
        #2;
        check_val("wr_we_before_rst", 32'(a_mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("async_we_drop", 32'(a_mem_we), 32'd0);
        check_val("async_wdata", a_mem_wdata, 32'd0);
        check_val("async_count", 32'(a_count), 32'd0);
        check_val("async_ready", 32'(a_in_ready), 32'd1);
        check_val("async_done_err", 32'({a_done, a_err}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        qa_addr.delete(); qa_data.delete();
        send(3'd4, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        repeat (4) @(negedge clk);
        check_val("post_rst_addr", qa_addr[0], 32'd0);
        check_val("post_rst_wdata", qa_data[0], 32'h00500093);

        // 4-word memory overflow
        do_reset();
        sel_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            send(3'd4, 5'(k), 5'd0, 5'd0, 13'(k), 1'b0);
        end
        repeat (4) @(negedge clk);
        check_val("ovf_nwrites", 32'(qb_data.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("ovf_addr%0d", k), qb_addr[k], 32'(k));
            check_val($sformatf("ovf_wdata%0d", k), qb_data[k],
                      32'h00000013 | (32'(k + 1) << 20) | (32'(k + 1) << 7));
        end
        check_val("ovf_done", 32'(b_done), 32'd1);
        check_val("ovf_err", 32'(b_err), 32'd1);
        check_val("ovf_count", 32'(b_count), 32'd4);
        in_valid = 1'b1; op_sel = 3'd4; rd = 5'd5; imm = 13'd5; last = 1'b0;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        check_val("ovf_fifth_rejected", 32'(qb_data.size()), 32'd4);
        check_val("ovf_ready", 32'(b_in_ready), 32'd0);
        check_val("ovf_a_untouched", 32'(qa_data.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
